// File: rtl/debug_input_capture.sv
// debug_input_capture: synchronise, debounce and latch KEY/SW events for the HPS over Avalon-MM
module debug_input_capture #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_SW-1:0]   sw
);
    localparam int N  = NUM_KEYS + NUM_SW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(DEBOUNCE_CYCLES + 2);
    logic [N-1:0]          sync1_q, sync2_q, stable_q, stable_d, edge_q, edge_d, mask_q, mask_d;
    logic [N-1:0]          rise, chg, set, clr;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic                  primed_q, primed_d;
    logic [31:0]           rdata_q, rdata_d, rmux;
    logic                  wr_edge, wr_mask, wr_ctrl, unused_wdata;
    assign unused_wdata = ^avs_writedata[31:N];
    // per-bit debounce: a new value must persist DEBOUNCE_CYCLES cycles; any agreement restarts the count
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i]    = (sync2_q[i] == stable_q[i] || cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q[i] + CW'(1);
            stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? sync2_q[i] : stable_q[i];
        end
    end
    // event capture, register writes, priming and the registered read path
    always_comb begin
        rise     = stable_d & ~stable_q;
        chg      = stable_d ^ stable_q;
        set      = primed_q ? {chg[N-1:NUM_KEYS], rise[NUM_KEYS-1:0]} : '0;
        wr_edge  = avs_write && avs_address == 2'd1;
        wr_mask  = avs_write && avs_address == 2'd2;
        wr_ctrl  = avs_write && avs_address == 2'd3 && avs_writedata[0];
        clr      = (wr_edge ? avs_writedata[N-1:0] : '0) | {N{wr_ctrl}};
        edge_d   = (edge_q & ~clr) | set;
        mask_d   = wr_mask ? avs_writedata[N-1:0] : mask_q;
        pcnt_d   = primed_q ? pcnt_q : pcnt_q + PW'(1);
        primed_d = primed_q | (pcnt_q == PW'(DEBOUNCE_CYCLES + 1));
        rmux     = avs_address == 2'd0 ? 32'(stable_q) :
                   avs_address == 2'd1 ? 32'(edge_q) :
                   avs_address == 2'd2 ? 32'(mask_q) : {31'b0, primed_q};
        rdata_d  = avs_read ? rmux : rdata_q;
    end
    // all state, with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            pcnt_q   <= '0;
            primed_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            sync1_q  <= {sw, ~key_n};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            pcnt_q   <= pcnt_d;
            primed_q <= primed_d;
            rdata_q  <= rdata_d;
        end
    end
    assign avs_readdata = rdata_q;
    assign irq          = |(edge_q & mask_q);
endmodule

// File: tb/tb_debug_input_capture.sv
// tb_debug_input_capture: directed bench for debug_input_capture with DEBOUNCE_CYCLES = 8
module tb_debug_input_capture;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    int          checks = 0;
    int          errors = 0;

    debug_input_capture #(.NUM_KEYS(4), .NUM_SW(10), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .key_n(key_n), .sw(sw)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick(1);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0; avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        key_n = 4'hF; sw = 10'h001;
        tick(3);
        checks++; if (avs_readdata !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL reset_outputs got rd=%h irq=%b exp rd=0 irq=0", avs_readdata, irq); end
        reset_n = 1'b1;
        tick(9);
        rd(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL state_before_settle got %h exp 0", d); end
        rd(2'd0, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL state_after_settle got %h exp 10", d); end
        rd(2'd3, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_primed got %h exp 1", d); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_after_prime got %h exp 0", d); end
    endtask

    task automatic test_press;
        logic [31:0] d;
        wr(2'd2, 32'h4);
        key_n = 4'b1011;
        tick(9);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
        tick(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_press got %b exp 1", irq); end
        rd(2'd0, d);
        checks++; if (d !== 32'h14) begin errors++; $display("FAIL state_pressed got %h exp 14", d); end
        rd(2'd1, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL edge_pressed got %h exp 4", d); end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        logic        hit;
        wr(2'd2, 32'h2);
        key_n = 4'b1001;
        hit = 1'b0;
        for (int i = 0; i < 7; i++) begin tick(1); hit |= irq; end
        key_n = 4'b1011;
        for (int i = 0; i < 14; i++) begin tick(1); hit |= irq; end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL glitch_irq got %b exp 0", hit); end
        rd(2'd0, d);
        checks++; if (d !== 32'h14) begin errors++; $display("FAIL glitch_state got %h exp 14", d); end
        rd(2'd1, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL glitch_edge got %h exp 4", d); end
        wr(2'd2, 32'h4);
    endtask

    task automatic test_release_switch;
        logic [31:0] d;
        key_n = 4'hF;
        tick(20);
        rd(2'd1, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL release_edge got %h exp 4", d); end
        rd(2'd0, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL release_state got %h exp 10", d); end
        sw = 10'h201;
        tick(20);
        sw = 10'h001;
        tick(20);
        rd(2'd1, d);
        checks++; if (d !== 32'h2004) begin errors++; $display("FAIL switch_edge got %h exp 2004", d); end
    endtask

    task automatic test_w1c;
        logic [31:0] d;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_clear got %b exp 1", irq); end
        wr(2'd1, 32'h4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear got %b exp 0", irq); end
        rd(2'd1, d);
        checks++; if (d !== 32'h2000) begin errors++; $display("FAIL edge_after_w1c got %h exp 2000", d); end
        wr(2'd1, 32'h0);
        rd(2'd1, d);
        checks++; if (d !== 32'h2000) begin errors++; $display("FAIL edge_w0_noop got %h exp 2000", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        avs_address = 2'd2; avs_writedata = 32'hFFFF_FFFF; avs_read = 1'b1; avs_write = 1'b1;
        tick(1);
        avs_read = 1'b0; avs_write = 1'b0;
        checks++; if (avs_readdata !== 32'h4) begin errors++; $display("FAIL rw_same_cycle got %h exp 4", avs_readdata); end
        rd(2'd2, d);
        checks++; if (d !== 32'h3FFF) begin errors++; $display("FAIL mask_width got %h exp 3fff", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_masked_on got %b exp 1", irq); end
        wr(2'd2, 32'h4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked_off got %b exp 0", irq); end
    endtask

    task automatic test_set_wins;
        logic [31:0] d;
        wr(2'd3, 32'h1);
        rd(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_clear got %h exp 0", d); end
        sw = 10'h201;
        tick(9);
        wr(2'd3, 32'h1);
        rd(2'd1, d);
        checks++; if (d !== 32'h2000) begin errors++; $display("FAIL set_wins got %h exp 2000", d); end
        rd(2'd0, d);
        checks++; if (d !== 32'h2010) begin errors++; $display("FAIL state_sw9 got %h exp 2010", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        key_n = 4'b1110;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        checks++; if (avs_readdata !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL midreset_outputs got rd=%h irq=%b exp rd=0 irq=0", avs_readdata, irq); end
        reset_n = 1'b1;
        rd(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_state got %h exp 0", d); end
        rd(2'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_ctrl got %h exp 0", d); end
        rd(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_mask got %h exp 0", d); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_edge got %h exp 0", d); end
        tick(6);
        rd(2'd0, d);
        checks++; if (d !== 32'h2011) begin errors++; $display("FAIL held_state got %h exp 2011", d); end
        rd(2'd3, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL reprimed got %h exp 1", d); end
        rd(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL held_no_edge got %h exp 0", d); end
    endtask

    initial begin
        test_reset;
        test_press;
        test_glitch;
        test_release_switch;
        test_w1c;
        test_back_to_back;
        test_set_wins;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debug_input_capture.md
Name: debug_input_capture

Overview:
- Avalon-MM slave peripheral that captures the board's user inputs for the HPS. It is the read-side counterpart of the debug output conduits that drive the LEDs and seven-segment displays.
- Synchronises and debounces the raw KEY (active-low) and SW inputs.
- Latches press and change events in a sticky edge register and raises a maskable interrupt.
- Sits in the Qsys system alongside the debug output block, with its conduits wired to the KEY and SW pins in the top level.

Parameters:
- NUM_KEYS, 4, number of pushbutton inputs.
- NUM_SW, 10, number of slider-switch inputs.
- DEBOUNCE_CYCLES, 500000, clock cycles an input must hold a new value before it is accepted (10 ms at 50 MHz); legal range 2..2^20.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- avs_address  in  2  register word select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed read latency of 1.
- irq  out  1  interrupt, active-high, level.
- key_n  in  NUM_KEYS  raw pushbuttons, asynchronous, 0 = pressed.
- sw  in  NUM_SW  raw switches, asynchronous.

Interface (already decided): one clock, clk; reset_n is synchronous and active-low. All state changes occur on the rising edge of clk.

Behaviour:
- Input vector in[13:0] = {sw, ~key_n}:
  - Keys occupy bits [NUM_KEYS-1:0].
  - Switches occupy bits [NUM_KEYS+NUM_SW-1:NUM_KEYS].
- Synchroniser: two flops per input.
  - Reset values: key synchroniser flops reset to "released" (pressed bit = 0); switch synchroniser flops reset to 0.
- Debounce, per bit, with counter width $clog2(DEBOUNCE_CYCLES):
  - If sync != stable: counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync != stable: stable <= sync and counter <= 0.
  - If sync == stable: counter <= 0 (a glitch restarts the count).
  - An input change at edge t is visible in stable at edge t+2+DEBOUNCE_CYCLES.
  - Pulses shorter than DEBOUNCE_CYCLES cycles never reach stable.
- Prime window:
  - After reset, the prime counter runs for DEBOUNCE_CYCLES+2 cycles, then sets primed = 1.
  - While primed = 0, stable still updates but no edge bits are set. This prevents switches that are already up at reset from raising spurious events.
- Edge register edge[13:0]:
  - Key bit sets on a stable 0->1 transition (press only).
  - Switch bit sets on either stable transition.
  - Bits are sticky until cleared.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Register map (word addresses):
  - 0 STATE (RO): {18'b0, stable}. Writes are ignored.
  - 1 EDGE (RW1C): read returns edge. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 2 MASK (RW): mask[13:0]; bits 31:14 read 0.
  - 3 CTRL: read returns {31'b0, primed}. A write with bit0 = 1 clears all edge bits (a simultaneous set still wins).
- Read timing:
  - avs_readdata is registered and loaded on the cycle after avs_read = 1; it holds its value otherwise.
  - A read and a write in the same cycle: the read returns pre-write contents.
- irq = |(edge & mask), driven from registers with no extra latency. It deasserts in the cycle after the clearing write.
- Reset values (reset_n = 0 at a clock edge):
  - stable = 0, all counters = 0, edge = 0, mask = 0, primed = 0.
  - avs_readdata = 0, irq = 0.
  - Reset mid-debounce discards the partial count.

Test Plan:
- Bench uses DEBOUNCE_CYCLES = 8; release reset with sw = 10'h001 and keys released -> STATE reads 0x10 after 10 cycles; EDGE = 0; CTRL = 1 after priming.
- After priming, drive key_n[2] low and hold -> STATE bit2 = 1 exactly 10 cycles later; EDGE = 0x004; with MASK = 0x004, irq rises in the same cycle as the edge bit.
- Drive key_n[1] low for 7 cycles, then high -> STATE and EDGE unchanged; irq stays 0.
- Release key_n[2] -> EDGE stays 0x004 (releases are not recorded); toggle sw[9] 0->1->0 with 20-cycle holds -> EDGE = 0x2004.
- Write EDGE = 0x004 -> reads 0x2000 and irq falls the next cycle. Then force a sw[9] stable change on the same edge as a CTRL write of 1 -> EDGE = 0x2000 (set wins).
- Assert reset_n = 0 for 1 cycle mid-debounce of key 0 -> all registers return 0; a key still held is reported in STATE after priming with no edge bit set.
